// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared definitions for the 8N1 UART receiver: frame format,
//            FSM state encoding and the bit-period helper used to derive
//            CYCLE/HALF from CLK_FREQ and BOUD_RATE (same formula as uart_tx).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  // 2-bit receiver state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per bit, integer division so TX and RX agree exactly
  function automatic int calc_cycle(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-stage synchronizer for an asynchronous 1-bit input.
//            Both stages reset to INIT so an idle-high line does not show a
//            spurious edge when reset is released.
// Ports    : clk   in  system clock
//            rst_n in  synchronous active-low reset
//            d     in  asynchronous input
//            q     out synchronized output (second stage)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1_d, stage1_q;
  logic stage2_d, stage2_q;

  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1_q <= INIT;
      stage2_q <= INIT;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Synchronizes rx_pin, detects the start-bit
//            falling edge, samples each bit at its centre and delivers the
//            byte with a 1-clk valid pulse, or a 1-clk frame_err pulse when
//            the stop bit is low.
// Ports    : clk       in   system clock
//            rst_n     in   synchronous active-low reset
//            rx_pin    in   asynchronous serial input, idle high
//            data      out  [7:0] last good byte, held until the next one
//            valid     out  1-clk pulse, data updated
//            frame_err out  1-clk pulse, stop bit sampled low
//            busy      out  high while a frame is being received
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BOUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CYCLE = calc_cycle(CLK_FREQ, BOUD_RATE);
  localparam int HALF  = CYCLE / 2;
  localparam int CNT_W = $clog2(CYCLE);

  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
  localparam logic [2:0]       BIT_LAST   = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e        state_d,     state_q;
  logic [CNT_W-1:0] cnt_d,       cnt_q;
  logic [2:0]       bit_idx_d,   bit_idx_q;
  logic [7:0]       shift_d,     shift_q;
  logic [7:0]       data_d,      data_q;
  logic             valid_d,     valid_q;
  logic             frame_err_d, frame_err_q;
  logic             rx_d_d,      rx_d_q;

  sync_2ff #(
    .INIT (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_d_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      rx_d_q      <= rx_d_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_d_d      = rx_s;

    case (state_q)
      ST_IDLE: begin
        // Edge-based: a line stuck low cannot retrigger a new frame
        if (rx_d_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Still low at mid start bit: genuine start, else a glitch
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CYCLE_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed
        if (cnt_q == CYCLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    data      = data_q;
    valid     = valid_q;
    frame_err = frame_err_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Drives 8N1 frames directly on
//            rx_pin and compares received bytes / error pulses against a
//            frame-level reference model (queues of expected bytes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ  = 27_000_000;
  localparam int BOUD_RATE = 115200;
  localparam int CYCLE     = CLK_FREQ / BOUD_RATE;
  localparam int HALF      = CYCLE / 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BOUD_RATE (BOUD_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin    (rx_pin),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor: records pulses, sampled on the falling edge
  int          vcnt = 0;
  int          fecnt = 0;
  int          overlap = 0;
  int          long_pulse = 0;
  logic        valid_prev = 1'b0;
  logic        fe_prev = 1'b0;
  logic [7:0]  rx_q[$];
  int unsigned vcyc_q[$];

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      rx_q.push_back(data);
      vcyc_q.push_back(cyc);
    end
    if (frame_err) fecnt++;
    if (valid && frame_err) overlap++;
    if ((valid && valid_prev) || (frame_err && fe_prev)) long_pulse++;
    valid_prev = valid;
    fe_prev    = frame_err;
  end

  // Reference model state: last byte that a good frame delivered
  logic [7:0] model_data = 8'h00;

  task automatic idle_clks(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; returns the cycle at which the start bit fell
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap,
                            output int unsigned fall_cyc);
    fall_cyc = cyc;
    rx_pin = 1'b0;
    idle_clks(CYCLE);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle_clks(CYCLE);
    end
    rx_pin = stop_bit;
    idle_clks(CYCLE);
    rx_pin = 1'b1;
    idle_clks(gap);
    if (stop_bit) model_data = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_clks(4);
    checks++;
    if ({data, valid, frame_err, busy} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b frame_err=%b busy=%b, expected 00 0 0 0",
               data, valid, frame_err, busy);
    end
    rst_n = 1'b1;
    idle_clks(4);
  endtask

  task automatic test_single();
    int v0 = vcnt, f0 = fecnt;
    int unsigned fall, lat;
    send_frame(8'h41, 1'b1, 20, fall);
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++; $display("FAIL single_valid_count: got %0d, expected 1", vcnt - v0);
    end
    checks++;
    if (data !== model_data) begin
      errors++; $display("FAIL single_data: got %h, expected %h", data, model_data);
    end
    checks++;
    if (fecnt - f0 !== 0) begin
      errors++; $display("FAIL single_frame_err: got %0d pulses, expected 0", fecnt - f0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_after: got %b, expected 0", busy);
    end
    // valid must land inside the stop bit: after its centre, before its end
    lat = (vcyc_q.size() > 0) ? vcyc_q[vcyc_q.size()-1] - fall : 0;
    checks++;
    if (lat < 9*CYCLE + HALF - 2 || lat >= 10*CYCLE) begin
      errors++;
      $display("FAIL single_latency: got %0d clk, expected within [%0d,%0d)",
               lat, 9*CYCLE + HALF - 2, 10*CYCLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3] = '{8'h55, 8'h00, 8'hFF};
    int base = rx_q.size();
    int f0 = fecnt;
    int unsigned fall;
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, (i == 2) ? 20 : 0, fall);
    checks++;
    if (rx_q.size() - base !== 3) begin
      errors++; $display("FAIL b2b_valid_count: got %0d, expected 3", rx_q.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base+i] !== bytes[i]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, rx_q[base+i], bytes[i]);
        end
      end
    end
    for (int i = 1; i < 3; i++) begin
      if (base + i < vcyc_q.size()) begin
        int unsigned sp = vcyc_q[base+i] - vcyc_q[base+i-1];
        checks++;
        if (sp < 10*CYCLE - 2 || sp > 10*CYCLE + 2) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d clk, expected about %0d", i, sp, 10*CYCLE);
        end
      end
    end
    checks++;
    if (fecnt - f0 !== 0) begin
      errors++; $display("FAIL b2b_frame_err: got %0d pulses, expected 0", fecnt - f0);
    end
  endtask

  task automatic test_glitch();
    int v0 = vcnt, f0 = fecnt;
    rx_pin = 1'b0;
    idle_clks(50);
    rx_pin = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL glitch_busy_set: got %b, expected 1", busy);
    end
    idle_clks(HALF + 4 - 50);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_clear: got %b, expected 0", busy);
    end
    idle_clks(2*CYCLE);
    checks++;
    if ((vcnt - v0) !== 0 || (fecnt - f0) !== 0) begin
      errors++; $display("FAIL glitch_pulses: got valid=%0d frame_err=%0d, expected 0 0",
                         vcnt - v0, fecnt - f0);
    end
  endtask

  task automatic test_frame_error();
    int v0 = vcnt, f0 = fecnt;
    logic [7:0] prev = model_data;
    int unsigned fall;
    send_frame(8'hA5, 1'b0, CYCLE, fall);
    checks++;
    if (fecnt - f0 !== 1) begin
      errors++; $display("FAIL ferr_count: got %0d, expected 1", fecnt - f0);
    end
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++; $display("FAIL ferr_valid: got %0d pulses, expected 0", vcnt - v0);
    end
    checks++;
    if (data !== prev) begin
      errors++; $display("FAIL ferr_data_hold: got %h, expected %h", data, prev);
    end
  endtask

  task automatic test_mid_reset();
    int v0, f0;
    int unsigned fall;
    logic [7:0] b = 8'hF8;  // bits 3..7 high: no new edge after the reset
    rx_pin = 1'b0;
    idle_clks(CYCLE);
    for (int i = 0; i < 3; i++) begin
      rx_pin = b[i];
      idle_clks(CYCLE);
    end
    rx_pin = b[3];
    idle_clks(HALF);
    rst_n = 1'b0;
    idle_clks(1);
    rst_n = 1'b1;
    model_data = 8'h00;
    checks++;
    if ({data, valid, frame_err, busy} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h valid=%b frame_err=%b busy=%b, expected 00 0 0 0",
               data, valid, frame_err, busy);
    end
    v0 = vcnt; f0 = fecnt;
    idle_clks(CYCLE - HALF - 1);
    for (int i = 4; i < 8; i++) begin
      rx_pin = b[i];
      idle_clks(CYCLE);
    end
    rx_pin = 1'b1;
    idle_clks(2*CYCLE);
    checks++;
    if ((vcnt - v0) !== 0 || (fecnt - f0) !== 0) begin
      errors++; $display("FAIL midreset_pulses: got valid=%0d frame_err=%0d, expected 0 0",
                         vcnt - v0, fecnt - f0);
    end
    v0 = vcnt;
    send_frame(8'h3C, 1'b1, 20, fall);
    checks++;
    if (vcnt - v0 !== 1 || data !== 8'h3C) begin
      errors++; $display("FAIL midreset_next_frame: got %0d pulses data=%h, expected 1 pulse data=3c",
                         vcnt - v0, data);
    end
  endtask

  task automatic test_break();
    int v0 = vcnt, f0 = fecnt;
    int unsigned fall;
    rx_pin = 1'b0;
    idle_clks(30*CYCLE);
    rx_pin = 1'b1;
    idle_clks(CYCLE);
    checks++;
    if (fecnt - f0 !== 1) begin
      errors++; $display("FAIL break_frame_err: got %0d, expected 1", fecnt - f0);
    end
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++; $display("FAIL break_valid: got %0d, expected 0", vcnt - v0);
    end
    v0 = vcnt;
    send_frame(8'h7E, 1'b1, 20, fall);
    checks++;
    if (vcnt - v0 !== 1 || data !== 8'h7E) begin
      errors++; $display("FAIL break_recover: got %0d pulses data=%h, expected 1 pulse data=7e",
                         vcnt - v0, data);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int base = rx_q.size();
    int f0 = fecnt;
    int exp_fe = 0;
    int unsigned fall;
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b   = 8'($urandom);
      logic       stp = ($urandom_range(0, 4) != 0);
      int         gap = $urandom_range(0, CYCLE);
      if (!stp && gap < 4) gap = 4;  // line must rise again before the next start
      if (stp) exp_q.push_back(b); else exp_fe++;
      send_frame(b, stp, gap, fall);
    end
    idle_clks(10);
    checks++;
    if (rx_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL rand_valid_count: got %0d, expected %0d", rx_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base+i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_data[%0d]: got %h, expected %h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (fecnt - f0 !== exp_fe) begin
      errors++; $display("FAIL rand_frame_err: got %0d, expected %0d", fecnt - f0, exp_fe);
    end
    checks++;
    if (data !== model_data) begin
      errors++; $display("FAIL rand_data_final: got %h, expected %h", data, model_data);
    end
  endtask

  task automatic test_pulse_shape();
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles, expected 0", overlap);
    end
    checks++;
    if (long_pulse !== 0) begin
      errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses, expected 0", long_pulse);
    end
  endtask

  initial begin
    idle_clks(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_reset();
    test_break();
    test_random();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
